// File: rtl/melody_player.sv
// Plays one of four short tunes from a constant ROM as a registered note/enable pair for a buzzer.
// A newer start with an equal or higher tune index pre-empts the current tune; a lower index is ignored.
module melody_player #(
  parameter int UNIT_CYC = 240000,
  parameter int GAP_CYC  = 24000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  output logic [6:0] note,
  output logic       en,
  output logic       busy,
  output logic       done
);

  localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [6:0]    REST_NOTE = 7'd127;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    curTune_q, curTune_d;
  logic [3:0]    idx_q, idx_d;
  logic [UW-1:0] unitCnt_q, unitCnt_d;
  logic [7:0]    durCnt_q, durCnt_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic [6:0]    note_q, note_d;
  logic          en_q, en_d;

  logic [5:0]    romAddr;
  logic [14:0]   romWord;
  logic [6:0]    romNote;
  logic [7:0]    romDur;
  logic          restart;

  // Each entry is {note, dur}; every address not listed reads as the end marker.
  assign romAddr = {curTune_q, idx_q};
  always_comb begin
    romWord = 15'd0;
    case (romAddr)
      6'd0:    romWord = {7'd49,  8'd5};
      6'd16:   romWord = {7'd37,  8'd3};
      6'd32:   romWord = {7'd44,  8'd10};
      6'd33:   romWord = {7'd127, 8'd2};
      6'd34:   romWord = {7'd49,  8'd10};
      6'd48:   romWord = {7'd37,  8'd15};
      6'd49:   romWord = {7'd41,  8'd15};
      6'd50:   romWord = {7'd44,  8'd15};
      6'd51:   romWord = {7'd49,  8'd30};
      default: romWord = 15'd0;
    endcase
  end
  assign romNote = romWord[14:8];
  assign romDur  = romWord[7:0];

  // From IDLE any tune is accepted; while busy only an equal or higher index pre-empts.
  assign restart = start && ((state_q == IDLE) || (sel >= curTune_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      curTune_q <= 2'd0;
      idx_q     <= 4'd0;
      unitCnt_q <= '0;
      durCnt_q  <= 8'd0;
      gapCnt_q  <= '0;
      note_q    <= 7'd0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      curTune_q <= curTune_d;
      idx_q     <= idx_d;
      unitCnt_q <= unitCnt_d;
      durCnt_q  <= durCnt_d;
      gapCnt_q  <= gapCnt_d;
      note_q    <= note_d;
      en_q      <= en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    curTune_d = curTune_q;
    idx_d     = idx_q;
    unitCnt_d = unitCnt_q;
    durCnt_d  = durCnt_q;
    gapCnt_d  = gapCnt_q;
    note_d    = note_q;
    en_d      = en_q;
    case (state_q)
      IDLE: ;
      FETCH: begin
        if (romDur == 8'd0) begin
          state_d = DONE;
          en_d    = 1'b0;
        end else begin
          state_d   = PLAY;
          durCnt_d  = romDur;
          unitCnt_d = '0;
          en_d      = (romNote != REST_NOTE);
          if (romNote != REST_NOTE) note_d = romNote;
        end
      end
      PLAY: begin
        // Units count down the duration; the last unit of the last count ends the note.
        if (unitCnt_q == UNIT_LAST) begin
          unitCnt_d = '0;
          durCnt_d  = durCnt_q - 8'd1;
          if (durCnt_q == 8'd1) begin
            state_d  = GAP;
            en_d     = 1'b0;
            gapCnt_d = '0;
          end
        end else begin
          unitCnt_d = unitCnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          gapCnt_d = '0;
          if (idx_q != 4'd15) begin
            idx_d   = idx_q + 4'd1;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A pre-empting start overrides everything above, including the return from DONE.
    if (restart) begin
      state_d   = FETCH;
      curTune_d = sel;
      idx_d     = 4'd0;
      unitCnt_d = '0;
      durCnt_d  = 8'd0;
      gapCnt_d  = '0;
      note_d    = note_q;
      en_d      = 1'b0;
    end
  end

  assign note = note_q;
  assign en   = en_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE) && !restart;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: expands each accepted tune into an expected per-cycle timeline
// and compares every cycle, plus hand-computed checkpoints for each scenario.
module tb_melody_player;

  localparam int UNIT = 4;
  localparam int GAPC = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] sel;
  logic [6:0] note;
  logic       en;
  logic       busy;
  logic       done;

  int compCount = 0;
  int failCount = 0;
  int rel = 0;

  melody_player #(.UNIT_CYC(UNIT), .GAP_CYC(GAPC)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .note(note), .en(en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       en;
    logic [6:0] note;
    logic       done;
  } exp_t;

  exp_t expQ[$];
  int   romNote[4][16];
  int   romDur[4][16];
  int   heldNote = 0;
  int   curTuneM = 0;

  task automatic initRom();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 16; i++) begin
        romNote[t][i] = 0;
        romDur[t][i]  = 0;
      end
    romNote[0][0] = 49;  romDur[0][0] = 5;
    romNote[1][0] = 37;  romDur[1][0] = 3;
    romNote[2][0] = 44;  romDur[2][0] = 10;
    romNote[2][1] = 127; romDur[2][1] = 2;
    romNote[2][2] = 49;  romDur[2][2] = 10;
    romNote[3][0] = 37;  romDur[3][0] = 15;
    romNote[3][1] = 41;  romDur[3][1] = 15;
    romNote[3][2] = 44;  romDur[3][2] = 15;
    romNote[3][3] = 49;  romDur[3][3] = 30;
  endtask

  task automatic pushN(int n, bit b, bit e, int nt, bit d);
    exp_t it;
    it.busy = b;
    it.en   = e;
    it.note = 7'(nt);
    it.done = d;
    for (int k = 0; k < n; k++) expQ.push_back(it);
  endtask

  // Expected outputs of every cycle after a tune is accepted, straight from the tune's note list.
  task automatic buildTune(int t, int startNote);
    int n;
    n = startNote;
    expQ.delete();
    for (int i = 0; i < 16; i++) begin
      pushN(1, 1'b1, 1'b0, n, 1'b0);
      if (romDur[t][i] == 0) begin
        pushN(1, 1'b1, 1'b0, n, 1'b1);
        return;
      end
      if (romNote[t][i] != 127) n = romNote[t][i];
      pushN(romDur[t][i] * UNIT, 1'b1, (romNote[t][i] != 127), n, 1'b0);
      pushN(GAPC, 1'b1, 1'b0, n, 1'b0);
    end
    pushN(1, 1'b1, 1'b0, n, 1'b1);
  endtask

  task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t item;
    bit   accept;
    if (rst) begin
      expQ.delete();
      heldNote = 0;
      curTuneM = 0;
    end else begin
      if (expQ.size() > 0) item = expQ.pop_front();
      else begin
        item.busy = 1'b0;
        item.en   = 1'b0;
        item.note = 7'(heldNote);
        item.done = 1'b0;
      end
      accept = start && (!item.busy || (int'(sel) >= curTuneM));
      checkOutput("busy", 8'(busy), 8'(item.busy));
      checkOutput("en",   8'(en),   8'(item.en));
      checkOutput("note", 8'(note), 8'(item.note));
      checkOutput("done", 8'(done), 8'(item.done && !accept));
      heldNote = int'(item.note);
      if (accept) begin
        curTuneM = int'(sel);
        buildTune(int'(sel), int'(item.note));
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    rel++;
  endtask

  task automatic runTo(int k);
    while (rel < k) nextCycle();
  endtask

  task automatic applyStimulus(bit s, logic [1:0] sl);
    start = s;
    sel   = sl;
  endtask

  task automatic beginTune(logic [1:0] sl);
    rel = 0;
    applyStimulus(1'b1, sl);
  endtask

  task automatic waitIdle(int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      nextCycle();
      n++;
    end
    checkOutput("waitIdle", 8'(busy), 8'd0);
    nextCycle();
  endtask

  task automatic pulseReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_en",   8'(en),   8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_note", 8'(note), 8'd0);
    checkOutput("rst_done", 8'(done), 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sel   = 2'd0;
    initRom();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_en",   8'(en),   8'd0);
    checkOutput("init_busy", 8'(busy), 8'd0);
    checkOutput("init_note", 8'(note), 8'd0);
    checkOutput("init_done", 8'(done), 8'd0);
    #1 rst = 1'b0;
    nextCycle();

    // sel wiggles with start low: nothing may move
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'(i));
      #3;
      checkOutput("idle_busy", 8'(busy), 8'd0);
      checkOutput("idle_note", 8'(note), 8'd0);
      checkOutput("idle_en",   8'(en),   8'd0);
      nextCycle();
    end

    // tune0
    beginTune(2'd0);
    runTo(1);  #3; checkOutput("t0_busy1", 8'(busy), 8'd1); checkOutput("t0_en1", 8'(en), 8'd0);
    runTo(2);  #3; checkOutput("t0_en2", 8'(en), 8'd1); checkOutput("t0_note2", 8'(note), 8'd49);
    runTo(21); #3; checkOutput("t0_en21", 8'(en), 8'd1);
    runTo(22); #3; checkOutput("t0_en22", 8'(en), 8'd0); checkOutput("t0_note22", 8'(note), 8'd49);
    runTo(24); #3; checkOutput("t0_done24", 8'(done), 8'd0);
    runTo(25); #3; checkOutput("t0_done25", 8'(done), 8'd1); checkOutput("t0_busy25", 8'(busy), 8'd1);
    runTo(26); #3; checkOutput("t0_busy26", 8'(busy), 8'd0); checkOutput("t0_done26", 8'(done), 8'd0);
    waitIdle(50);

    // tune2 with its rest in the middle
    beginTune(2'd2);
    runTo(41); #3; checkOutput("t2_en41", 8'(en), 8'd1); checkOutput("t2_note41", 8'(note), 8'd44);
    runTo(50); #3; checkOutput("t2_en50", 8'(en), 8'd0); checkOutput("t2_note50", 8'(note), 8'd44);
    runTo(56); #3; checkOutput("t2_en56", 8'(en), 8'd1); checkOutput("t2_note56", 8'(note), 8'd49);
    runTo(99); #3; checkOutput("t2_done99", 8'(done), 8'd1);
    waitIdle(50);

    // tune1 pre-empted by tune3, then a lower-index start that must be ignored, then reset
    beginTune(2'd1);
    runTo(6); applyStimulus(1'b1, 2'd3);
    runTo(8);  #3; checkOutput("pre_en8", 8'(en), 8'd1); checkOutput("pre_note8", 8'(note), 8'd37);
    runTo(20); applyStimulus(1'b1, 2'd0);
    runTo(71); #3; checkOutput("pre_note71", 8'(note), 8'd41); checkOutput("pre_en71", 8'(en), 8'd1);
    runTo(100);
    pulseReset();
    rel = 0;
    runTo(40);
    checkOutput("post_rst_busy", 8'(busy), 8'd0);
    nextCycle();

    // start during the DONE cycle restarts without a done pulse
    beginTune(2'd1);
    runTo(17); applyStimulus(1'b1, 2'd1);
    #3; checkOutput("dn_done17", 8'(done), 8'd0); checkOutput("dn_busy17", 8'(busy), 8'd1);
    runTo(19); #3; checkOutput("dn_en19", 8'(en), 8'd1); checkOutput("dn_note19", 8'(note), 8'd37);
    runTo(34); #3; checkOutput("dn_done34", 8'(done), 8'd1);
    runTo(35); #3; checkOutput("dn_busy35", 8'(busy), 8'd0);
    waitIdle(50);

    $display("[TB] %0d tests run, %0d failed", compCount, failCount);
    $finish;
  end

endmodule
